// File: rtl/gf180mcu_fd_sc_mcu9t5v0__regsnq_bank.sv
// Register bank with per-bit synchronous set, scan shift, parallel load and a
// sticky lock that freezes shift/load until the next reset.
module gf180mcu_fd_sc_mcu9t5v0__regsnq_bank #(
  parameter int unsigned         WIDTH   = 8,
  parameter logic [WIDTH-1:0]    RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             E,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] SETN,
  input  logic             SE,
  input  logic             SI,
  input  logic             LOCK,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             CHG,
  output logic             LOCKED
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shift_w;
  logic             chg_q, chg_d;
  logic             unlocked_w;

  // Lock state register
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock is sticky: only reset leaves ST_LOCKED
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: if (LOCK) state_d = ST_LOCKED;
      ST_LOCKED:   state_d = ST_LOCKED;
      default:     state_d = ST_UNLOCKED;
    endcase
  end

  assign unlocked_w = (state_q == ST_UNLOCKED);

  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign shift_w = SI;
    end else begin : g_shift_wn
      assign shift_w = {q_q[WIDTH-2:0], SI};
    end
  endgenerate

  // Per-bit priority: set, then shift, then load, then hold
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!SETN[i]) begin
        q_d[i] = 1'b1;
      end else if (SE && unlocked_w) begin
        q_d[i] = shift_w[i];
      end else if (E && unlocked_w) begin
        q_d[i] = D[i];
      end
    end
    chg_d = (q_d != q_q);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      q_q   <= RST_VAL;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
    end
  end

  assign Q      = q_q;
  assign SO     = q_q[WIDTH-1];
  assign CHG    = chg_q;
  assign LOCKED = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__regsnq_bank.sv
// Scoreboard bench: three widths (1, 8, 32) share one stimulus stream and are
// checked against a word-level reference model.
module tb_gf180mcu_fd_sc_mcu9t5v0__regsnq_bank;

  logic        CLK = 1'b0;
  logic        RN;
  logic        E;
  logic [31:0] d32;
  logic [31:0] setn32;
  logic        SE;
  logic        SI;
  logic        LOCK;

  logic [0:0]  q1;
  logic [7:0]  q8;
  logic [31:0] q32;
  logic        so1, so8, so32;
  logic        chg1, chg8, chg32;
  logic        lk1, lk8, lk32;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__regsnq_bank #(.WIDTH(1)) u1 (
    .CLK(CLK), .RN(RN), .E(E), .D(d32[0:0]), .SETN(setn32[0:0]), .SE(SE),
    .SI(SI), .LOCK(LOCK), .Q(q1), .SO(so1), .CHG(chg1), .LOCKED(lk1));

  gf180mcu_fd_sc_mcu9t5v0__regsnq_bank #(.WIDTH(8)) u8 (
    .CLK(CLK), .RN(RN), .E(E), .D(d32[7:0]), .SETN(setn32[7:0]), .SE(SE),
    .SI(SI), .LOCK(LOCK), .Q(q8), .SO(so8), .CHG(chg8), .LOCKED(lk8));

  gf180mcu_fd_sc_mcu9t5v0__regsnq_bank #(.WIDTH(32)) u32 (
    .CLK(CLK), .RN(RN), .E(E), .D(d32), .SETN(setn32), .SE(SE),
    .SI(SI), .LOCK(LOCK), .Q(q32), .SO(so32), .CHG(chg32), .LOCKED(lk32));

  typedef struct packed {
    logic [2:0][31:0] q;
    logic [2:0]       chg;
    logic             locked;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        kick  = 1'b0;

  // Reference model state
  logic [31:0] m_q   [3];
  logic        m_chg [3];
  logic        m_locked;
  int unsigned wid   [3];

  function automatic logic [31:0] mask_of(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_q[k]   = mask_of(wid[k]);
      m_chg[k] = 1'b0;
    end
    m_locked = 1'b0;
  endfunction

  function automatic void model_edge(input logic e, input logic [31:0] d,
                                     input logic [31:0] setn, input logic se,
                                     input logic si, input logic lock);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] msk, sh, base, nxt;
      msk  = mask_of(wid[k]);
      sh   = ((m_q[k] << 1) | {31'd0, si}) & msk;
      if (m_locked)  base = m_q[k];
      else if (se)   base = sh;
      else if (e)    base = d & msk;
      else           base = m_q[k];
      nxt      = base | (~setn & msk);
      m_chg[k] = (nxt != m_q[k]);
      m_q[k]   = nxt;
    end
    if (lock) m_locked = 1'b1;
  endfunction

  function automatic exp_t snapshot();
    exp_t x;
    for (int k = 0; k < 3; k++) begin
      x.q[k]   = m_q[k];
      x.chg[k] = m_chg[k];
    end
    x.locked = m_locked;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge or asynchronous-reset kick
  initial begin
    forever begin
      @(posedge CLK or posedge kick);
      #1;
      if (sb.size() != 0) begin
        exp_t x;
        x = sb.pop_front();
        chk("q_w1",   {31'd0, q1},  x.q[0]);
        chk("q_w8",   {24'd0, q8},  x.q[1]);
        chk("q_w32",  q32,          x.q[2]);
        chk("so_w1",  {31'd0, so1},  {31'd0, x.q[0][0]});
        chk("so_w8",  {31'd0, so8},  {31'd0, x.q[1][7]});
        chk("so_w32", {31'd0, so32}, {31'd0, x.q[2][31]});
        chk("chg_w1",  {31'd0, chg1},  {31'd0, x.chg[0]});
        chk("chg_w8",  {31'd0, chg8},  {31'd0, x.chg[1]});
        chk("chg_w32", {31'd0, chg32}, {31'd0, x.chg[2]});
        chk("locked_w1",  {31'd0, lk1},  {31'd0, x.locked});
        chk("locked_w8",  {31'd0, lk8},  {31'd0, x.locked});
        chk("locked_w32", {31'd0, lk32}, {31'd0, x.locked});
      end
    end
  end

  // One clock cycle of stimulus, applied at the falling edge
  task automatic st(input logic rn, input logic e, input logic [31:0] d,
                    input logic [31:0] setn, input logic se, input logic si,
                    input logic lock);
    @(negedge CLK);
    RN = rn; E = e; d32 = d; setn32 = setn; SE = se; SI = si; LOCK = lock;
    if (!rn) model_reset();
    else     model_edge(e, d, setn, se, si, lock);
    sb.push_back(snapshot());
  endtask

  // Reset pulse wholly between two rising edges
  task automatic mid_reset();
    @(posedge CLK);
    #2;
    RN = 1'b0;
    model_reset();
    sb.push_back(snapshot());
    kick = 1'b1;
    #2;
    kick = 1'b0;
    RN   = 1'b1;
  endtask

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  initial begin
    wid[0] = 1; wid[1] = 8; wid[2] = 32;
    RN = 1'b0; E = 1'b0; d32 = '0; setn32 = ONES; SE = 1'b0; SI = 1'b0; LOCK = 1'b0;
    model_reset();

    // Inputs are ignored while reset is held
    st(1'b0, 1'b1, 32'h0000_003C, 32'h0, 1'b0, 1'b0, 1'b1);
    st(1'b0, 1'b0, 32'h0, ONES, 1'b1, 1'b0, 1'b0);

    // Load, repeat load of identical data
    st(1'b1, 1'b1, 32'h0000_003C, ONES, 1'b0, 1'b0, 1'b0);
    st(1'b1, 1'b1, 32'h0000_003C, ONES, 1'b0, 1'b0, 1'b0);
    st(1'b1, 1'b0, 32'h0, ONES, 1'b0, 1'b0, 1'b0);

    // Shift 1,0,1,1 then four zeros from a cleared register
    st(1'b1, 1'b1, 32'h0, ONES, 1'b0, 1'b0, 1'b0);
    st(1'b1, 1'b0, 32'h0, ONES, 1'b1, 1'b1, 1'b0);
    st(1'b1, 1'b0, 32'h0, ONES, 1'b1, 1'b0, 1'b0);
    st(1'b1, 1'b0, 32'h0, ONES, 1'b1, 1'b1, 1'b0);
    st(1'b1, 1'b0, 32'h0, ONES, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) st(1'b1, 1'b0, 32'h0, ONES, 1'b1, 1'b0, 1'b0);

    // Per-bit set over load, then over shift (SE wins over E)
    st(1'b1, 1'b1, 32'h0, ONES, 1'b0, 1'b0, 1'b0);
    st(1'b1, 1'b1, 32'h0000_00F0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    st(1'b1, 1'b1, 32'h0, ONES, 1'b0, 1'b0, 1'b0);
    st(1'b1, 1'b1, 32'h0000_00F0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    st(1'b1, 1'b0, 32'h0, ONES, 1'b1, 1'b0, 1'b0);

    // Lock on a load edge; load/shift frozen, set still works, LOCK=0 ignored
    st(1'b1, 1'b1, 32'h0, ONES, 1'b0, 1'b0, 1'b0);
    st(1'b1, 1'b1, 32'h0000_0055, ONES, 1'b0, 1'b0, 1'b1);
    st(1'b1, 1'b1, 32'h0000_00AA, ONES, 1'b0, 1'b0, 1'b0);
    st(1'b1, 1'b0, 32'h0, ONES, 1'b1, 1'b1, 1'b0);
    st(1'b1, 1'b0, 32'h0, 32'hFFFF_FF7F, 1'b0, 1'b0, 1'b0);
    st(1'b1, 1'b0, 32'h0, ONES, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while locked, then load
    mid_reset();
    st(1'b1, 1'b1, 32'h0000_0012, ONES, 1'b0, 1'b0, 1'b0);
    st(1'b1, 1'b0, 32'h0, ONES, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        rn, e, se, si, lk;
      logic [31:0] d, sn;
      rn = ($urandom_range(0, 49) != 0);
      e  = 1'(($urandom & 32'd1));
      se = ($urandom_range(0, 2) == 0);
      si = 1'(($urandom & 32'd1));
      lk = ($urandom_range(0, 39) == 0);
      d  = $urandom;
      sn = ($urandom_range(0, 3) == 0) ? $urandom : ONES;
      st(rn, e, d, sn, se, si, lk);
      if ($urandom_range(0, 59) == 0) mid_reset();
    end

    @(posedge CLK);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__regsnq_bank.md
GF180MCU_FD_SC_MCU9T5V0__REGSNQ_BANK -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__regsnq_bank

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits, legal range 1..32.
REQ-002 Parameter: RST_VAL, default all-ones of WIDTH bits, value Q takes under reset.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RN  input  1  reset, asynchronous assert, active-low; deassertion takes effect at the next CLK rising edge.
REQ-005 E  input  1  load enable, active-high.
REQ-006 D  input  WIDTH  parallel load data.
REQ-007 SETN  input  WIDTH  per-bit synchronous set, active-low.
REQ-008 SE  input  1  scan-shift enable, active-high.
REQ-009 SI  input  1  scan serial input.
REQ-010 LOCK  input  1  lock request, active-high, sampled on CLK.
REQ-011 Q  output  WIDTH  registered data.
REQ-012 SO  output  1  scan serial output, equal to Q[WIDTH-1] (flop output, no added logic stage).
REQ-013 CHG  output  1  registered pulse; high for one cycle when Q changed on the preceding edge.
REQ-014 LOCKED  output  1  registered lock-state flag.

Function
REQ-015 Lock FSM SHALL have exactly two states, UNLOCKED and LOCKED; LOCKED is output on LOCKED.
REQ-016 UNLOCKED -> LOCKED SHALL occur on a CLK edge with LOCK=1; LOCKED is exited only by RN assertion; LOCK=0 while LOCKED has no effect.
REQ-017 Per-bit next-value priority on each CLK edge, highest first: SETN[i]=0 -> 1; else SE=1 and UNLOCKED -> shift; else E=1 and UNLOCKED -> D[i]; else hold.
REQ-018 Shift SHALL be Q <= {Q[WIDTH-2:0], SI}; for WIDTH=1, Q <= SI.
REQ-019 SETN SHALL override shift/load per bit only; bits with SETN[i]=1 follow the remaining priority in the same cycle (a shift with a SETN-forced bit forwards the forced 1 on the next shift, not the pre-set value).
REQ-020 LOCKED state SHALL ignore SE and E; SETN remains effective while locked.
REQ-021 The edge that performs the UNLOCKED->LOCKED transition SHALL still apply that cycle's shift/load (lock takes effect from the following edge).
REQ-022 CHG SHALL be registered as (Q_next != Q) at each edge, so CHG is high in the same cycle Q shows its new value and low otherwise; a load of identical data yields CHG=0.
REQ-023 Simultaneous SE=1 and E=1 SHALL shift; D is ignored.
REQ-024 No combinational path from any input to Q, CHG, LOCKED or SO.

Reset
REQ-025 RN=0 SHALL immediately force Q=RST_VAL, CHG=0, LOCKED=0 (state UNLOCKED), independent of CLK.
REQ-026 RN asserted mid-shift or mid-lock SHALL abandon the operation; no partial state survives.
REQ-027 While RN=0, all inputs SHALL be ignored; the first CLK edge with RN=1 follows REQ-017 normally; CHG is not asserted for the reset transition itself.

Verification (WIDTH=8, RST_VAL=8'hFF)
REQ-028 Reset then E=1, D=8'h3C for one edge -> Q=8'h3C, CHG=1 that cycle, CHG=0 next cycle; repeat load of 8'h3C -> CHG stays 0.
REQ-029 Q=8'h00, SE=1, SI sequence 1,0,1,1 over 4 edges -> Q=8'h0B, SO=0; continue with 4 more SI=0 edges -> Q=8'hB0, SO=1.
REQ-030 Q=8'h00, E=1, D=8'hF0, SETN=8'hFE -> Q=8'hF1; same edge with SE=1 instead, SI=0 -> Q=8'h01.
REQ-031 LOCK=1 with E=1, D=8'h55 on one edge -> Q=8'h55, LOCKED=1; next edges E=1 D=8'hAA and SE=1 -> Q stays 8'h55; SETN=8'h7F -> Q=8'hD5; LOCK=0 -> LOCKED stays 1.
REQ-032 RN pulsed low between CLK edges while LOCKED=1, Q=8'hD5 -> Q=8'hFF, LOCKED=0, CHG=0 immediately; after release E=1 D=8'h12 -> Q=8'h12.
REQ-033 Parameter sweep WIDTH=1 and WIDTH=32: shift, load, per-bit set and lock behave per REQ-017..REQ-022; for WIDTH=1, SO=Q.
